fifo_in_arbiter: RTL and testbench

Weighted round-robin arbiter that shares the DUT's single fifo_in stream port (data_in/data_in_vld/data_in_rdy) between two upstream fifo_in requesters. It grants one requester at a time for a burst of up to WEIGHTk beats and forwards the beats through a one-entry registered output stage. It sits between the fifo_in agents' interfaces and the DUT input in the top harness, or in front of any shared valid/ready sink.

---
 rtl/fifo_in_arbiter_if.sv | 12 +
 rtl/fifo_in_arbiter.sv | 124 ++++++++++++
 tb/tb_fifo_in_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_in_arbiter_if.sv
// Valid/ready stream bundle shared by the arbiter's two requester ports and its output port.
// master drives data/vld and receives rdy; slave is the opposite side.
interface fifo_in_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic                  vld;
    logic                  rdy;

    modport master (output data, output vld, input rdy);
    modport slave  (input data, input vld, output rdy);
endinterface

// File: rtl/fifo_in_arbiter.sv
// Weighted round-robin arbiter: two valid/ready requesters share one sink.
// Each grant lasts up to WEIGHTk beats and feeds a one-entry registered output stage.
module fifo_in_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int WEIGHT0    = 4,
    parameter int WEIGHT1    = 4
) (
    input  logic              clk,
    input  logic              rst,
    fifo_in_arbiter_if.slave  in0,
    fifo_in_arbiter_if.slave  in1,
    fifo_in_arbiter_if.master out,
    output logic [1:0]        owner
);
    localparam int WMAX  = (WEIGHT0 > WEIGHT1) ? WEIGHT0 : WEIGHT1;
    localparam int CNT_W = (WMAX > 1) ? $clog2(WMAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST0 = CNT_W'(WEIGHT0 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST1 = CNT_W'(WEIGHT1 - 1);

    // Encoding doubles as the owner output: bit k set means requester k holds the grant.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    last_q, last_d;
    logic                    out_vld_q;
    logic [DATA_WIDTH-1:0]   out_data_q;

    logic [1:0]              req_vld;
    logic [1:0]              req_rdy;
    logic [1:0]              req_xfer;
    logic [DATA_WIDTH-1:0]   req_data [2];
    logic                    load_en;
    logic                    xfer_any;

    assign req_vld     = {in1.vld, in0.vld};
    assign req_data[0] = in0.data;
    assign req_data[1] = in1.data;
    assign load_en     = !out_vld_q | out.rdy;
    assign owner       = state_q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign req_rdy[gi]  = load_en & owner[gi];
            assign req_xfer[gi] = req_vld[gi] & req_rdy[gi];
        end
    endgenerate

    assign in0.rdy  = req_rdy[0];
    assign in1.rdy  = req_rdy[1];
    assign xfer_any = |req_xfer;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req_vld == 2'b11)  state_d = last_q ? OWN0 : OWN1;
                else if (req_vld[0])   state_d = OWN0;
                else if (req_vld[1])   state_d = OWN1;
            end
            OWN0: begin
                if (req_xfer[0]) begin
                    if (cnt_q == CNT_LAST0) begin
                        cnt_d = '0;
                        if (req_vld[1]) state_d = OWN1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (!req_vld[0]) begin
                    cnt_d   = '0;
                    state_d = req_vld[1] ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (req_xfer[1]) begin
                    if (cnt_q == CNT_LAST1) begin
                        cnt_d = '0;
                        if (req_vld[0]) state_d = OWN0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (!req_vld[1]) begin
                    cnt_d   = '0;
                    state_d = req_vld[0] ? OWN0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A fresh grant restarts the burst and becomes the tie-break reference.
        if (state_d != state_q && state_d != IDLE) begin
            cnt_d  = '0;
            last_d = (state_d == OWN1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            if (xfer_any) begin
                out_vld_q  <= 1'b1;
                out_data_q <= req_xfer[1] ? req_data[1] : req_data[0];
            end else if (out.rdy) begin
                out_vld_q  <= 1'b0;
            end
        end
    end

    assign out.vld  = out_vld_q;
    assign out.data = out_data_q;
endmodule

// File: tb/tb_fifo_in_arbiter.sv
// Randomized and directed bench for fifo_in_arbiter with an in-bench grant/output model
// checked every cycle, plus literal pins and a second instance with weights 2:1.
module tb_fifo_in_arbiter;
    localparam int W0 = 4;
    localparam int W1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    fifo_in_arbiter_if #(.DATA_WIDTH(32)) in0_if ();
    fifo_in_arbiter_if #(.DATA_WIDTH(32)) in1_if ();
    fifo_in_arbiter_if #(.DATA_WIDTH(32)) o_if ();
    logic [1:0] owner;

    fifo_in_arbiter #(.DATA_WIDTH(32), .WEIGHT0(W0), .WEIGHT1(W1)) u_dut (
        .clk(clk), .rst(rst), .in0(in0_if), .in1(in1_if), .out(o_if), .owner(owner)
    );

    fifo_in_arbiter_if #(.DATA_WIDTH(32)) a0_if ();
    fifo_in_arbiter_if #(.DATA_WIDTH(32)) a1_if ();
    fifo_in_arbiter_if #(.DATA_WIDTH(32)) ao_if ();
    logic [1:0] owner_b;

    fifo_in_arbiter #(.DATA_WIDTH(32), .WEIGHT0(2), .WEIGHT1(1)) u_dut_b (
        .clk(clk), .rst(rst), .in0(a0_if), .in1(a1_if), .out(ao_if), .owner(owner_b)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;
    bit rst_req = 1;

    // stimulus state
    logic [31:0] q0[$], q1[$];
    bit cur_v0 = 0, cur_v1 = 0;
    int p0 = 0, p1 = 0, prdy = 100;
    bit rdy_pat[$];

    // model state: owner 0 none / 1 req0 / 2 req1
    bit          m_vld = 0;
    logic [31:0] m_data = '0;
    int          m_own = 0, m_cnt = 0, m_last = 1;
    bit          acc0 = 0, acc1 = 0;

    // output log of the main instance
    logic [31:0] rx_q[$];
    int          rx_cyc[$];
    int          cyc = 0;

    // weight 2:1 instance
    bit          a_run = 0;
    bit          a0_acc = 0, a1_acc = 0;
    int          a0_idx = 0, a1_idx = 0;
    logic [31:0] a_rx[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: grant rules and the one-entry output register, from the arbitration rules.
    always @(posedge clk) begin
        int  nown, ncnt, nlast, w;
        bit  le, x0, x1, mine, other;
        if (rst) begin
            m_vld <= 0; m_data <= '0; m_own <= 0; m_cnt <= 0; m_last <= 1;
            acc0 <= 0; acc1 <= 0;
        end else begin
            le = !m_vld || o_if.rdy;
            x0 = (m_own == 1) && le && in0_if.vld;
            x1 = (m_own == 2) && le && in1_if.vld;
            acc0 <= x0;
            acc1 <= x1;
            if (x0 || x1) begin
                m_vld  <= 1;
                m_data <= x0 ? in0_if.data : in1_if.data;
            end else if (o_if.rdy) begin
                m_vld <= 0;
            end
            nown = m_own; ncnt = m_cnt; nlast = m_last;
            if (m_own == 0) begin
                if (in0_if.vld && in1_if.vld) nown = (m_last == 1) ? 1 : 2;
                else if (in0_if.vld)          nown = 1;
                else if (in1_if.vld)          nown = 2;
            end else begin
                mine  = (m_own == 1) ? in0_if.vld : in1_if.vld;
                other = (m_own == 1) ? in1_if.vld : in0_if.vld;
                w     = (m_own == 1) ? W0 : W1;
                if (x0 || x1) begin
                    if (m_cnt == w - 1) begin
                        ncnt = 0;
                        if (other) nown = 3 - m_own;
                    end else begin
                        ncnt = m_cnt + 1;
                    end
                end else if (!mine) begin
                    ncnt = 0;
                    nown = other ? 3 - m_own : 0;
                end
            end
            if (nown != 0 && nown != m_own) begin
                ncnt  = 0;
                nlast = nown - 1;
            end
            m_own <= nown; m_cnt <= ncnt; m_last <= nlast;
        end
    end

    // Compare process: every cycle, after inputs settle.
    always @(negedge clk) begin
        bit le;
        #1;
        if (chk_en) begin
            le = !m_vld || o_if.rdy;
            chk("out_vld", {31'd0, o_if.vld}, {31'd0, m_vld});
            chk("out_data", o_if.data, m_data);
            chk("owner", {30'd0, owner}, m_own);
            chk("in0_rdy", {31'd0, in0_if.rdy}, {31'd0, le && (m_own == 1)});
            chk("in1_rdy", {31'd0, in1_if.rdy}, {31'd0, le && (m_own == 2)});
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && o_if.vld && o_if.rdy) begin
            rx_q.push_back(o_if.data);
            rx_cyc.push_back(cyc);
        end
        a0_acc <= !rst && a0_if.vld && a0_if.rdy;
        a1_acc <= !rst && a1_if.vld && a1_if.rdy;
        if (a_run && !rst && ao_if.vld && ao_if.rdy) a_rx.push_back(ao_if.data);
    end

    task automatic tick();
        @(negedge clk);
        rst = rst_req;
        if (cur_v0 && acc0) begin void'(q0.pop_front()); cur_v0 = 0; end
        if (cur_v1 && acc1) begin void'(q1.pop_front()); cur_v1 = 0; end
        if (!cur_v0 && q0.size() > 0 && $urandom_range(99) < p0) cur_v0 = 1;
        if (!cur_v1 && q1.size() > 0 && $urandom_range(99) < p1) cur_v1 = 1;
        in0_if.vld  = cur_v0;
        in0_if.data = cur_v0 ? q0[0] : $urandom;
        in1_if.vld  = cur_v1;
        in1_if.data = cur_v1 ? q1[0] : $urandom;
        if (rdy_pat.size() > 0) o_if.rdy = rdy_pat.pop_front();
        else                    o_if.rdy = ($urandom_range(99) < prdy);
        if (a_run) begin
            if (a0_acc) a0_idx++;
            if (a1_acc) a1_idx++;
            a0_if.vld = 1; a0_if.data = 32'hA000 + a0_idx;
            a1_if.vld = 1; a1_if.data = 32'hB000 + a1_idx;
        end else begin
            a0_if.vld = 0; a1_if.vld = 0;
        end
        ao_if.rdy = 1;
    endtask

    task automatic do_reset();
        rst_req = 1;
        tick();
        tick();
        rst_req = 0;
        rx_q.delete();
        rx_cyc.delete();
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        prdy = 100;
        while ((q0.size() > 0 || q1.size() > 0 || cur_v0 || cur_v1 || m_vld) && n < maxc) begin
            tick();
            n++;
        end
        if (n >= maxc) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d cycles required below %0d", n, maxc);
        end
        tick();
        tick();
    endtask

    initial begin
        rst = 1;
        in0_if.vld = 0; in0_if.data = '0; in1_if.vld = 0; in1_if.data = '0; o_if.rdy = 0;
        a0_if.vld = 0; a0_if.data = '0; a1_if.vld = 0; a1_if.data = '0; ao_if.rdy = 1;

        // reset state
        tick(); tick();
        chk_en = 1;
        #2;
        chk("rst_out_vld", {31'd0, o_if.vld}, 32'd0);
        chk("rst_out_data", o_if.data, 32'd0);
        chk("rst_owner", {30'd0, owner}, 32'd0);
        chk("rst_in0_rdy", {31'd0, in0_if.rdy}, 32'd0);
        chk("rst_in1_rdy", {31'd0, in1_if.rdy}, 32'd0);
        rst_req = 0;

        // single requester: 0x11,0x22,0x33
        q0 = '{32'h11, 32'h22, 32'h33}; p0 = 100; p1 = 0; prdy = 100;
        tick();
        tick(); #2;
        chk("single_owner", {30'd0, owner}, 32'd1);
        chk("single_out_vld_bubble", {31'd0, o_if.vld}, 32'd0);
        tick(); #2; chk("single_beat0", o_if.data, 32'h11);
        tick(); #2; chk("single_beat1", o_if.data, 32'h22);
        tick(); #2; chk("single_beat2", o_if.data, 32'h33);
        chk("single_in1_rdy", {31'd0, in1_if.rdy}, 32'd0);
        tick(); #2; chk("single_back_idle", {30'd0, owner}, 32'd0);
        drain(50);

        // both continuously valid, weights 4:4
        do_reset();
        for (int i = 0; i < 20; i++) begin q0.push_back(32'h100 + i); q1.push_back(32'h200 + i); end
        p0 = 100; p1 = 100;
        drain(200);
        for (int i = 0; i < 4; i++) begin
            chk("rr_req0_first", rx_q[i], 32'h100 + i);
            chk("rr_req1_next", rx_q[4 + i], 32'h200 + i);
        end
        chk("rr_req0_again", rx_q[8], 32'h104);
        chk("rr_no_bubble", rx_cyc[15] - rx_cyc[0], 32'd15);
        chk("rr_count", rx_q.size(), 32'd40);

        // backpressure during a req1 burst
        do_reset();
        for (int i = 0; i < 6; i++) q1.push_back(32'hC0 + i);
        p0 = 0; p1 = 100;
        rdy_pat = '{1, 1, 1, 0, 0, 1, 1, 0, 1};
        drain(100);
        chk("bp_count", rx_q.size(), 32'd6);
        for (int i = 0; i < 6; i++) chk("bp_order", rx_q[i], 32'hC0 + i);

        // owner drops mid-burst while the other is valid
        do_reset();
        q0 = '{32'h5A}; q1 = '{32'hB0, 32'hB1, 32'hB2}; p0 = 100; p1 = 100; prdy = 100;
        tick();
        tick(); #2; chk("drop_owner0", {30'd0, owner}, 32'd1);
        tick(); #2; chk("drop_beat", o_if.data, 32'h5A);
        tick(); #2; chk("drop_switch", {30'd0, owner}, 32'd2);
        chk("drop_in1_rdy", {31'd0, in1_if.rdy}, 32'd1);
        tick(); tick();
        tick(); #2; chk("drop_hold_owner1", {30'd0, owner}, 32'd2);
        tick(); #2; chk("drop_idle", {30'd0, owner}, 32'd0);
        drain(50);

        // reset pulse while output is stalled
        do_reset();
        for (int i = 0; i < 5; i++) q0.push_back(32'hD0 + i);
        for (int i = 0; i < 3; i++) q1.push_back(32'hE0 + i);
        p0 = 100; p1 = 100; prdy = 0;
        tick(); tick(); tick();
        tick(); #2; chk("pre_rst_out_vld", {31'd0, o_if.vld}, 32'd1);
        rst_req = 1;
        tick();
        rst_req = 0; prdy = 100;
        tick(); #2;
        chk("post_rst_out_vld", {31'd0, o_if.vld}, 32'd0);
        chk("post_rst_owner", {30'd0, owner}, 32'd0);
        chk("post_rst_in0_rdy", {31'd0, in0_if.rdy}, 32'd0);
        chk("post_rst_in1_rdy", {31'd0, in1_if.rdy}, 32'd0);
        tick(); #2; chk("post_rst_tie_req0", {30'd0, owner}, 32'd1);
        drain(100);

        // randomized traffic with occasional resets
        for (int seg = 0; seg < 12; seg++) begin
            p0 = $urandom_range(100, 20); p1 = $urandom_range(100, 20); prdy = $urandom_range(100, 30);
            if ($urandom_range(3) == 0) begin
                rst_req = 1; tick(); rst_req = 0;
            end
            for (int c = 0; c < 100; c++) begin
                if (q0.size() < 4) q0.push_back($urandom);
                if (q1.size() < 4) q1.push_back($urandom);
                tick();
            end
        end
        drain(300);

        // weights 2:1, both continuously valid
        do_reset();
        a_run = 1;
        begin
            int n = 0;
            while (a_rx.size() < 30 && n < 200) begin tick(); n++; end
        end
        a_run = 0;
        chk("w21_count", (a_rx.size() >= 30) ? 32'd30 : a_rx.size(), 32'd30);
        for (int i = 0; i < 30 && i < a_rx.size(); i++) begin
            logic [31:0] e;
            e = (i % 3 < 2) ? 32'hA000 + 2 * (i / 3) + (i % 3) : 32'hB000 + i / 3;
            chk("w21_pattern", a_rx[i], e);
        end

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
